turn_input_conditioner: RTL
===========================

# turn_input_conditioner

Conditions the two raw turn push-buttons (KEY2 = right, KEY3 = left) before they reach `snake_game_fsm`. Each key is synchronised to `clock_25`, debounced, and edge-detected. A single pending-turn register then holds the most recent press until the next `game_tik`. It drives `right_P`/`left_P` as one-cycle pulses aligned with that `game_tik`, so exactly one turn is applied per snake step and no press is lost between steps.

## Interface
- `DEBOUNCE_CYCLES`, 250000: consecutive stable cycles required to accept a level change (10 ms at 25 MHz).
- `DEBOUNCE_BITS`, 18: counter width; must satisfy 2^DEBOUNCE_BITS > DEBOUNCE_CYCLES.
- `clock_25` input 1: the single clock, 25 MHz pixel clock.
- `reset` input 1: asynchronous, active-low.
- `KEY2` input 1: raw right button, active-low, asynchronous to `clock_25`.
- `KEY3` input 1: raw left button, active-low, asynchronous to `clock_25`.
- `game_tik` input 1: one-cycle step strobe from `game_delay_fsm`.
- `sync_reset` input 1: synchronous game restart from `snake_game_fsm`; clears the pending turn.
- `right_P` output 1: registered one-cycle pulse requesting a right turn, coincident with `game_tik`.
- `left_P` output 1: registered one-cycle pulse requesting a left turn, coincident with `game_tik`.
- `any_press` output 1: registered one-cycle pulse on any accepted press (start-screen exit).

## Operation
- Synchroniser: two flops per key, reset to 1 (released). Downstream logic uses the inverted synchronised level, so `pressed` = 1.
- Debounce FSM per key has four states.
  - `UP`: `pressed` = 1 → `WAIT_DOWN`, counter cleared.
  - `WAIT_DOWN`: counter increments while `pressed` = 1. If `pressed` drops, return to `UP`. When the counter reaches `DEBOUNCE_CYCLES`-1 → `DOWN` and emit `press_evt` for one cycle.
  - `DOWN`: `pressed` = 0 → `WAIT_UP`, counter cleared.
  - `WAIT_UP`: mirror of `WAIT_DOWN`. Reaching `DEBOUNCE_CYCLES`-1 → `UP`; no event on release.
- Pending register `pend[1:0]` encodes 00 none, 01 right, 10 left.
  - A right event alone sets 01. A left event alone sets 10.
  - The latest press overrides an earlier pending one (11 is never stored).
  - Right and left events in the same cycle are both discarded and `pend` is unchanged.
- On `game_tik`: `right_P` = `pend`==01 and `left_P` = `pend`==10, registered for that one cycle; `pend` clears.
- If a press event and `game_tik` occur in the same cycle, the event is not output on this tik. It is stored in `pend` (after the clear) for the next tik.
- `sync_reset` clears `pend` and suppresses outputs that cycle. Debounce FSMs are unaffected, so a held key does not re-fire.
- `any_press` = OR of both `press_evt` signals, registered. It is independent of `game_tik` and fires even when the events cancel.
- Holding a key produces exactly one event.

## Timing
- Reset values:
  - synchroniser flops 1;
  - FSMs in `UP`, counters 0;
  - `pend` 00;
  - `right_P`, `left_P`, `any_press` all 0.
- Press to `press_evt`: 2 sync cycles + `DEBOUNCE_CYCLES` cycles of stable level.
- `any_press` asserts 1 cycle after `press_evt`.
- `right_P`/`left_P` assert in the cycle after the `game_tik` edge sample, and stay high for exactly one cycle. Pending latency is therefore bounded by one game step + 1 cycle.
- Reset asserted mid-debounce: everything returns to reset values immediately. After release, a still-held key must re-qualify for the full `DEBOUNCE_CYCLES`.
- Counter saturates and never wraps; it is only compared in the `WAIT_*` states.

## Structure
- Shared package holds:
  - the debounce FSM state encoding (`UP`, `WAIT_DOWN`, `DOWN`, `WAIT_UP`);
  - the `pend` encodings (`TURN_NONE`, `TURN_RIGHT`, `TURN_LEFT`);
  - the default `DEBOUNCE_CYCLES`.
- Sub-module `key_debouncer`: synchroniser, counter, FSM, and `press_evt` output. It is instantiated twice. The top level holds `pend` and the output registers.
- In `game_wrapper`, this block replaces the direct `~KEY2`/`~KEY3` connections to `snake_game_fsm`.

## Test plan
Simulation runs with `DEBOUNCE_CYCLES`=4.
- Clean press: KEY2 low for 20 cycles, then `game_tik` at cycle 30 → `any_press` one pulse at cycle 7; `right_P` high only at cycle 31; `left_P` stays 0.
- Bounce: KEY3 toggles every 2 cycles for 12 cycles, then stays low → exactly one left event, 6 cycles after it settles; no extra `any_press` pulses.
- Override and cancel:
  - KEY2 event, then KEY3 event, then `game_tik` → `left_P` only.
  - Both events in the same cycle → no turn pulse on the next tik, but `any_press` = 1.
- Event on the tik cycle: `press_evt` coincides with `game_tik` → no pulse on that tik; the turn pulse appears on the following `game_tik`.
- Held key: KEY2 held for 1000 cycles across 5 `game_tik`s → exactly one `right_P`.
- Reset and restart:
  - `reset` low during `WAIT_DOWN` → all outputs 0; after release, a held key needs a full 4+2 cycles.
  - `sync_reset` with a right turn pending → next `game_tik` gives no pulse.

Source files
------------

// File: rtl/turn_input_conditioner_pkg.sv
// Shared constants for the turn-button conditioning path: debounce FSM state
// encoding, pending-turn encoding and the default debounce length.
package turn_input_conditioner_pkg;

    // 10 ms at 25 MHz
    localparam int DEFAULT_DEBOUNCE_CYCLES = 250000;

    // Debounce FSM states
    localparam logic [1:0] UP        = 2'b00;
    localparam logic [1:0] WAIT_DOWN = 2'b01;
    localparam logic [1:0] DOWN      = 2'b10;
    localparam logic [1:0] WAIT_UP   = 2'b11;

    // Pending-turn encodings; 2'b11 is never stored
    localparam logic [1:0] TURN_NONE  = 2'b00;
    localparam logic [1:0] TURN_RIGHT = 2'b01;
    localparam logic [1:0] TURN_LEFT  = 2'b10;

endpackage : turn_input_conditioner_pkg

// File: rtl/turn_input_conditioner_if.sv
// Button / game-step bundle between the game wrapper and the turn conditioner.
// KEY2/KEY3 are the raw active-low buttons; right_P/left_P/any_press are the
// conditioned one-cycle pulses handed to snake_game_fsm.
interface turn_input_conditioner_if;
    logic KEY2;
    logic KEY3;
    logic game_tik;
    logic sync_reset;
    logic right_P;
    logic left_P;
    logic any_press;

    modport master (
        output KEY2,
        output KEY3,
        output game_tik,
        output sync_reset,
        input  right_P,
        input  left_P,
        input  any_press
    );

    modport slave (
        input  KEY2,
        input  KEY3,
        input  game_tik,
        input  sync_reset,
        output right_P,
        output left_P,
        output any_press
    );
endinterface : turn_input_conditioner_if

// File: rtl/turn_input_conditioner_key_debouncer.sv
// One push-button: two-flop synchroniser, saturating stability counter and a
// four-state debounce FSM. press_evt pulses for one cycle when a press has been
// stable for DEBOUNCE_CYCLES cycles; releases produce no event.
module key_debouncer
    import turn_input_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int DEBOUNCE_BITS   = 18
) (
    input  logic clock_25,
    input  logic reset,
    input  logic key_n,
    output logic press_evt
);

    localparam logic [DEBOUNCE_BITS-1:0] CNT_LAST = DEBOUNCE_BITS'(DEBOUNCE_CYCLES - 1);
    localparam logic [DEBOUNCE_BITS-1:0] CNT_MAX  = {DEBOUNCE_BITS{1'b1}};
    localparam logic [DEBOUNCE_BITS-1:0] CNT_ZERO = {DEBOUNCE_BITS{1'b0}};
    localparam logic [DEBOUNCE_BITS-1:0] CNT_ONE  = DEBOUNCE_BITS'(1);

    logic                     sync1_q, sync1_d;
    logic                     sync2_q, sync2_d;
    logic [1:0]               state_q, state_d;
    logic [DEBOUNCE_BITS-1:0] cnt_q, cnt_d;
    logic                     pressed_s;
    logic [DEBOUNCE_BITS-1:0] cnt_inc_s;

    // Synchroniser chain input and saturating counter increment
    always_comb begin
        sync1_d   = key_n;
        sync2_d   = sync1_q;
        pressed_s = ~sync2_q;
        if (cnt_q == CNT_MAX) begin
            cnt_inc_s = cnt_q;
        end else begin
            cnt_inc_s = cnt_q + CNT_ONE;
        end
    end

    // Debounce FSM: a level change must hold for DEBOUNCE_CYCLES cycles
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        press_evt = 1'b0;
        case (state_q)
            UP: begin
                if (pressed_s) begin
                    state_d = WAIT_DOWN;
                    cnt_d   = CNT_ZERO;
                end else begin
                    state_d = UP;
                end
            end
            WAIT_DOWN: begin
                if (!pressed_s) begin
                    state_d = UP;
                    cnt_d   = CNT_ZERO;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = DOWN;
                    cnt_d     = CNT_ZERO;
                    press_evt = 1'b1;
                end else begin
                    cnt_d = cnt_inc_s;
                end
            end
            DOWN: begin
                if (!pressed_s) begin
                    state_d = WAIT_UP;
                    cnt_d   = CNT_ZERO;
                end else begin
                    state_d = DOWN;
                end
            end
            WAIT_UP: begin
                if (pressed_s) begin
                    state_d = DOWN;
                    cnt_d   = CNT_ZERO;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = UP;
                    cnt_d   = CNT_ZERO;
                end else begin
                    cnt_d = cnt_inc_s;
                end
            end
            default: begin
                state_d = UP;
                cnt_d   = CNT_ZERO;
            end
        endcase
    end

    // State, counter and synchroniser flops; synchroniser idles released (1)
    always_ff @(posedge clock_25 or negedge reset) begin
        if (!reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            state_q <= UP;
            cnt_q   <= CNT_ZERO;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule : key_debouncer

// File: rtl/turn_input_conditioner.sv
// Turn-button conditioner: debounces KEY2 (right) and KEY3 (left), keeps the
// most recent accepted press in a pending register and releases it as a
// one-cycle right_P/left_P pulse on the next game_tik, so every snake step
// applies at most one turn and no press between steps is lost.
module turn_input_conditioner
    import turn_input_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int DEBOUNCE_BITS   = 18
) (
    input  logic                     clock_25,
    input  logic                     reset,
    turn_input_conditioner_if.slave  bus
);

    logic       right_evt_s;
    logic       left_evt_s;
    logic [1:0] pend_q, pend_d;
    logic [1:0] pend_base_s;
    logic       right_p_q, right_p_d;
    logic       left_p_q, left_p_d;
    logic       any_press_q, any_press_d;

    key_debouncer #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .DEBOUNCE_BITS   (DEBOUNCE_BITS)
    ) u_right_key (
        .clock_25  (clock_25),
        .reset     (reset),
        .key_n     (bus.KEY2),
        .press_evt (right_evt_s)
    );

    key_debouncer #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .DEBOUNCE_BITS   (DEBOUNCE_BITS)
    ) u_left_key (
        .clock_25  (clock_25),
        .reset     (reset),
        .key_n     (bus.KEY3),
        .press_evt (left_evt_s)
    );

    // Pending-turn update and output pulse selection. A tik drains pend first;
    // a press in the same cycle lands in pend afterwards, for the next tik.
    always_comb begin
        right_p_d   = 1'b0;
        left_p_d    = 1'b0;
        pend_base_s = pend_q;
        pend_d      = pend_q;
        any_press_d = right_evt_s | left_evt_s;
        if (bus.sync_reset) begin
            pend_base_s = TURN_NONE;
            pend_d      = TURN_NONE;
        end else begin
            if (bus.game_tik) begin
                right_p_d   = (pend_q == TURN_RIGHT);
                left_p_d    = (pend_q == TURN_LEFT);
                pend_base_s = TURN_NONE;
            end else begin
                pend_base_s = pend_q;
            end
            case ({right_evt_s, left_evt_s})
                2'b10:   pend_d = TURN_RIGHT;
                2'b01:   pend_d = TURN_LEFT;
                // no event, or simultaneous events that cancel each other
                default: pend_d = pend_base_s;
            endcase
        end
    end

    // Pending register and registered output pulses
    always_ff @(posedge clock_25 or negedge reset) begin
        if (!reset) begin
            pend_q      <= TURN_NONE;
            right_p_q   <= 1'b0;
            left_p_q    <= 1'b0;
            any_press_q <= 1'b0;
        end else begin
            pend_q      <= pend_d;
            right_p_q   <= right_p_d;
            left_p_q    <= left_p_d;
            any_press_q <= any_press_d;
        end
    end

    assign bus.right_P   = right_p_q;
    assign bus.left_P    = left_p_q;
    assign bus.any_press = any_press_q;

endmodule : turn_input_conditioner
